// File: rtl/stock_manager.sv
// Inventory stage for the vending machine: per-item stock, sales statistics and
// sold-out flags, updated by one purchase/restock/clear request at a time.
module stock_manager #(
  parameter logic [2:0] INIT_STOCK = 3'd5
) (
  input  logic        clk,
  input  logic        EN,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_item,
  input  logic [2:0]  req_qty,
  output logic [20:0] left,
  output logic [6:0]  soldout,
  output logic [7:0]  sold_total,
  output logic [9:0]  revenue,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, RESP} state_t;

  localparam logic [1:0] OP_BUY = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;

  state_t      state;
  logic [1:0]  op_p0;
  logic [2:0]  item_p0;
  logic [2:0]  qty_p0;
  logic        err_p1;

  logic [4:0]  base;
  logic [2:0]  cur_stock;
  logic [3:0]  add_sum;
  logic [5:0]  product;
  logic [10:0] sold_sum;
  logic [10:0] rev_sum;
  logic        illegal;
  logic [2:0]  new_slice;
  logic [20:0] next_left;

  function automatic logic [2:0] unit_price(input logic [2:0] item);
    case (item)
      3'd1:    unit_price = 3'd2;
      3'd2:    unit_price = 3'd3;
      3'd3:    unit_price = 3'd3;
      3'd4:    unit_price = 3'd4;
      3'd5:    unit_price = 3'd5;
      3'd6:    unit_price = 3'd5;
      3'd7:    unit_price = 3'd7;
      default: unit_price = 3'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_sold(input logic [10:0] sum);
    sat_sold = (sum > 11'd255) ? 8'hFF : sum[7:0];
  endfunction

  function automatic logic [9:0] sat_rev(input logic [10:0] sum);
    sat_rev = (sum > 11'd1023) ? 10'h3FF : sum[9:0];
  endfunction

  function automatic logic [6:0] empty_flags(input logic [20:0] bus);
    logic [6:0] f;
    f = 7'd0;
    for (int k = 0; k < 7; k++) f[k] = (bus[3*k +: 3] == 3'd0);
    empty_flags = f;
  endfunction

  // Bit offset of the addressed slice; meaningless for item 0, which is always rejected.
  assign base      = ({2'b00, item_p0} - 5'd1) * 5'd3;
  assign cur_stock = 3'(left >> base);
  assign add_sum   = {1'b0, cur_stock} + {1'b0, qty_p0};
  assign product   = {3'b000, unit_price(item_p0)} * {3'b000, qty_p0};
  assign sold_sum  = {3'b000, sold_total} + {8'd0, qty_p0};
  assign rev_sum   = {1'b0, revenue} + {5'd0, product};
  assign new_slice = (op_p0 == OP_BUY) ? (cur_stock - qty_p0) : add_sum[2:0];

  always_comb begin
    illegal = 1'b1;
    case (op_p0)
      OP_BUY:  illegal = (item_p0 == 3'd0) || (qty_p0 > cur_stock);
      OP_ADD:  illegal = (item_p0 == 3'd0) || (add_sum > 4'd7);
      OP_CLR:  illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    next_left = left;
    if (item_p0 != 3'd0)
      next_left = (left & ~(21'h7 << base)) | ({18'd0, new_slice} << base);
  end

  always_ff @(posedge clk or negedge EN) begin
    if (!EN) begin
      state      <= IDLE;
      op_p0      <= 2'b00;
      item_p0    <= 3'd0;
      qty_p0     <= 3'd0;
      err_p1     <= 1'b0;
      left       <= {7{INIT_STOCK}};
      soldout    <= (INIT_STOCK == 3'd0) ? 7'h7F : 7'h00;
      sold_total <= 8'd0;
      revenue    <= 10'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        // IDLE: accept and latch a request
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req_valid) begin
            op_p0   <= req_op;
            item_p0 <= req_item;
            qty_p0  <= req_qty;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        // CHECK: register legality against the current stock
        CHECK: begin
          err_p1 <= illegal;
          state  <= APPLY;
        end
        // APPLY: commit legal requests; done/err become visible in RESP
        APPLY: begin
          if (!err_p1) begin
            case (op_p0)
              OP_BUY: begin
                left       <= next_left;
                soldout    <= empty_flags(next_left);
                sold_total <= sat_sold(sold_sum);
                revenue    <= sat_rev(rev_sum);
              end
              OP_ADD: begin
                left    <= next_left;
                soldout <= empty_flags(next_left);
              end
              OP_CLR: begin
                sold_total <= 8'd0;
                revenue    <= 10'd0;
              end
              default: ;
            endcase
          end
          done  <= 1'b1;
          err   <= err_p1;
          state <= RESP;
        end
        // RESP: single-cycle response, then back to IDLE
        RESP: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/stock_manager.md
Name: stock_manager

Overview:
- Upstream inventory stage for the vending machine.
- Holds the remaining count of the 7 goods and processes one purchase, restock or clear-statistics request at a time via a busy/done handshake.
- Drives the packed 21-bit remaining-stock bus consumed by the admin scrolling display, plus sales statistics and sold-out flags.

Parameters:
- INIT_STOCK, 3'd5, per-item stock loaded on reset (legal range 0..7).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- EN  input  1  reset: asynchronous, active-low, clears or loads all state.
- req_valid  input  1  request strobe; sampled only in IDLE.
- req_op  input  2  operation: 00 purchase, 01 restock, 10 clear statistics, 11 reserved.
- req_item  input  3  item number 1..7; 0 is invalid.
- req_qty  input  3  units to buy or add, 0..7.
- left  output  21  remaining stock; bits [3k-1:3k-3] hold item k (item 1 = [2:0], item 7 = [20:18]).
- soldout  output  7  bit k-1 = 1 when item k stock is 0.
- sold_total  output  8  total units sold, saturating at 255.
- revenue  output  10  accumulated revenue, saturating at 1023.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse when a request completes.
- err  output  1  valid only with done; 1 = request rejected, no state changed.

Behaviour:
- Reset (EN=0, async):
  - every item slice = INIT_STOCK.
  - soldout = 0 if INIT_STOCK≠0, else 7'h7F.
  - sold_total = 0, revenue = 0, busy = 0, done = 0, err = 0.
  - FSM = IDLE.
  - Any request in flight is dropped; no done is issued.
- FSM states: IDLE, CHECK, APPLY, RESP.
  - IDLE: if req_valid=1, latch op/item/qty and go to CHECK (acceptance cycle T). Otherwise stay.
  - CHECK (T+1): evaluate legality, register the error flag, then go to APPLY.
  - APPLY (T+2): if legal, update state; if illegal, change nothing. Then go to RESP.
  - RESP (T+3): done=1 and err=registered flag for exactly this cycle, then return to IDLE. A new request may be accepted at T+4.
- Requests are ignored while busy=1 (req_valid is don't-care, no queueing).
- Purchase (op 00): qty 0 is legal and a no-op with done, err=0.
  - Illegal if item=0 or qty > stock[item].
  - Legal: stock[item] -= qty.
  - sold_total += qty, saturating at 255.
  - revenue += qty*price[item], saturating at 1023.
  - Unit prices for items 1..7: 2, 3, 3, 4, 5, 5, 7. Product width is 6 bits (max 49). Sums are computed at 11 bits before clamping.
- Restock (op 01): illegal if item=0 or stock[item]+qty > 7 (evaluate at 4 bits). Legal: stock[item] += qty. Statistics are unchanged.
- Clear (op 10): item and qty are ignored. sold_total=0 and revenue=0; stock is unchanged. Always legal.
- Reserved (op 11): always err=1.
- soldout is registered and updated in the same cycle as left, so it is always consistent with left.
- Only the addressed item slice changes; all other slices hold.

Test Plan:
- Reset with INIT_STOCK=5 → left=21'o5555555, soldout=0, sold_total=0, revenue=0, busy=0.
- Purchase item 7, qty 2 → busy high T..T+3, done at T+3, err=0. Then left[20:18]=3, sold_total=2, revenue=14.
- Purchase item 3, qty 6 from stock 5 → done with err=1, left unchanged. Then buy qty 5 → left[8:6]=0, soldout[2]=1, revenue+=15.
- Restock item 3, qty 7 from 0 → left[8:6]=7, soldout[2]=0. Then restock qty 1 → err=1, stock stays 7.
- Item 0 purchase, op 11, and req_valid pulsed during busy → first two give err=1. The pulse during busy yields no extra done and no state change.
- Revenue saturation: repeated purchases of item 7 qty 7 with restocks until revenue clamps at 1023. Then clear → revenue=0, sold_total=0, stock kept. Assert EN low at APPLY cycle → state returns to reset values and no done pulse.
